// File: rtl/systolic_job_seq.sv
// Job sequencer for the systolic4 array: streams A/B operands from a source RAM into the
// array over ibus, kicks the array, polls for completion and copies results to a destination RAM.
module systolic_job_seq #(
    parameter int          NPE      = 2,
    parameter logic [15:0] A_BASE   = 16'h0000,
    parameter logic [15:0] B_BASE   = 16'h0400,
    parameter logic [15:0] CTRL_ADR = 16'h0800,
    parameter logic [15:0] STAT_ADR = 16'h0801,
    parameter logic [15:0] RES_BASE = 16'h0C00,
    parameter logic [15:0] TMO      = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_start,
    input  logic [7:0]  job_len,
    input  logic [15:0] src_base,
    input  logic [15:0] dst_base,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_ren,
    output logic [15:0] mem_radr,
    input  logic [15:0] mem_rdata,
    output logic        mem_wen,
    output logic [15:0] mem_wadr,
    output logic [15:0] mem_wdata,
    output logic        ren,
    output logic [15:0] ibus_radr,
    input  logic [15:0] ibus_rdata,
    output logic        wen,
    output logic [15:0] ibus_wadr,
    output logic [15:0] ibus_wdata
);

    typedef enum logic [2:0] {IDLE, LD_A, LD_B, KICK, POLL, RD_RES, FIN} state_t;

    localparam logic [8:0] RES_LAST = 9'(NPE * NPE - 1);

    state_t      state, state_d;
    logic [7:0]  len_q;
    logic [15:0] src_q, dst_q;
    logic [8:0]  n_words, k, k_d;
    logic [15:0] tmo_cnt, tmo_d;
    logic        poll_phase, phase_d;
    logic        fin_err, fin_err_d;
    logic        start_job;
    logic        stat_ren, res_ren, kick_wen;
    logic        ld_pend, res_pend;
    logic [15:0] ld_wadr, res_wadr;

    // Next-state logic; source reads and ibus reads are issued combinationally from the state.
    always_comb begin
        state_d   = state;
        k_d       = k;
        tmo_d     = tmo_cnt;
        phase_d   = poll_phase;
        fin_err_d = fin_err;
        start_job = 1'b0;
        mem_ren   = 1'b0;
        mem_radr  = '0;
        stat_ren  = 1'b0;
        res_ren   = 1'b0;
        kick_wen  = 1'b0;
        case (state)
            IDLE: begin
                if (job_start) begin
                    if (job_len == 8'd0) begin
                        state_d   = FIN;
                        fin_err_d = 1'b1;
                    end else begin
                        start_job = 1'b1;
                        state_d   = LD_A;
                        k_d       = '0;
                        fin_err_d = 1'b0;
                    end
                end
            end
            LD_A: begin
                mem_ren  = 1'b1;
                mem_radr = src_q + 16'(k);
                if (k == n_words - 9'd1) begin
                    k_d     = '0;
                    state_d = LD_B;
                end else begin
                    k_d = k + 9'd1;
                end
            end
            LD_B: begin
                mem_ren  = 1'b1;
                mem_radr = src_q + 16'(n_words) + 16'(k);
                if (k == n_words - 9'd1) begin
                    k_d     = '0;
                    state_d = KICK;
                end else begin
                    k_d = k + 9'd1;
                end
            end
            // The last B word is still in flight on entry; the control write waits one slot for it.
            KICK: begin
                if (!ld_pend) begin
                    kick_wen = 1'b1;
                    state_d  = POLL;
                    tmo_d    = '0;
                    phase_d  = 1'b0;
                end
            end
            POLL: begin
                stat_ren = !poll_phase;
                if (poll_phase && ibus_rdata[0]) begin
                    state_d = RD_RES;
                    k_d     = '0;
                end else if (tmo_cnt == TMO - 16'd1) begin
                    state_d   = FIN;
                    fin_err_d = 1'b1;
                end else begin
                    tmo_d   = tmo_cnt + 16'd1;
                    phase_d = !poll_phase;
                end
            end
            RD_RES: begin
                res_ren = 1'b1;
                if (k == RES_LAST) begin
                    state_d = FIN;
                end else begin
                    k_d = k + 9'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, job registers and the one-deep read-to-write pipelines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            n_words    <= '0;
            k          <= '0;
            tmo_cnt    <= '0;
            poll_phase <= 1'b0;
            fin_err    <= 1'b0;
            ld_pend    <= 1'b0;
            ld_wadr    <= '0;
            res_pend   <= 1'b0;
            res_wadr   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            k          <= k_d;
            tmo_cnt    <= tmo_d;
            poll_phase <= phase_d;
            fin_err    <= fin_err_d;
            if (start_job) begin
                len_q   <= job_len;
                src_q   <= src_base;
                dst_q   <= dst_base;
                n_words <= 9'(NPE * int'(job_len));
            end
            ld_pend  <= mem_ren;
            ld_wadr  <= ((state == LD_B) ? B_BASE : A_BASE) + 16'(k);
            res_pend <= res_ren;
            res_wadr <= dst_q + 16'(k);
            done     <= (state == FIN);
            err      <= (state == FIN) && fin_err;
        end
    end

    // Bus muxing; write data passes straight through from the read side of each pipeline.
    always_comb begin
        ren       = stat_ren | res_ren;
        ibus_radr = '0;
        if (stat_ren) begin
            ibus_radr = STAT_ADR;
        end else if (res_ren) begin
            ibus_radr = RES_BASE + 16'(k);
        end
        wen        = ld_pend | kick_wen;
        ibus_wadr  = '0;
        ibus_wdata = '0;
        if (ld_pend) begin
            ibus_wadr  = ld_wadr;
            ibus_wdata = mem_rdata;
        end else if (kick_wen) begin
            ibus_wadr  = CTRL_ADR;
            ibus_wdata = {7'd0, 1'b1, len_q};
        end
        mem_wen   = res_pend;
        mem_wadr  = res_pend ? res_wadr : 16'd0;
        mem_wdata = res_pend ? ibus_rdata : 16'd0;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_systolic_job_seq.sv
// Self-checking bench for systolic_job_seq: transaction scoreboard built from the job
// parameters, RAM/status models, and directed jobs covering wrap, timeout, zero length and abort.
module tb_systolic_job_seq;

    localparam int          NPE      = 2;
    localparam logic [15:0] A_BASE   = 16'h0000;
    localparam logic [15:0] B_BASE   = 16'h0400;
    localparam logic [15:0] CTRL_ADR = 16'h0800;
    localparam logic [15:0] STAT_ADR = 16'h0801;
    localparam logic [15:0] RES_BASE = 16'h0C00;
    localparam logic [15:0] TMO_TB   = 16'd100;

    typedef struct packed {
        logic [15:0] adr;
        logic [15:0] dat;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_start = 1'b0;
    logic [7:0]  job_len = '0;
    logic [15:0] src_base = '0;
    logic [15:0] dst_base = '0;
    logic        busy, done, err;
    logic        mem_ren, mem_wen, ren, wen;
    logic [15:0] mem_radr, mem_wadr, mem_wdata, ibus_radr, ibus_wadr, ibus_wdata;
    logic [15:0] mem_rdata = 16'hBEEF;
    logic [15:0] ibus_rdata = 16'hDEAD;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    xfer_t       exp_ibus_w[$];
    xfer_t       exp_mem_w[$];
    logic [15:0] exp_mem_r[$];
    logic [15:0] exp_res_r[$];
    xfer_t       e_w, e_m;

    int          stat_mode = 0;
    logic [7:0]  cur_len = '0;
    int          start_cyc, first_rd_cyc, rd_idx, ld_wr_idx, last_ld_cyc;
    int          ctrl_cyc, stat_cnt, last_stat_cyc, stat1_cyc;
    int          first_res_cyc, res_idx, mem_w_idx, last_mem_w_cyc, done_seen, done_cyc;
    logic        ctrl_seen = 1'b0;
    logic        done_err;
    logic [15:0] ctrl_data, first_ld_data, last_ld_data, first_mw_adr, first_mw_data;

    always #5 clk = ~clk;

    systolic_job_seq #(.NPE(NPE), .TMO(TMO_TB)) dut (
        .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_len(job_len),
        .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done), .err(err),
        .mem_ren(mem_ren), .mem_radr(mem_radr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_wadr(mem_wadr), .mem_wdata(mem_wdata),
        .ren(ren), .ibus_radr(ibus_radr), .ibus_rdata(ibus_rdata),
        .wen(wen), .ibus_wadr(ibus_wadr), .ibus_wdata(ibus_wdata)
    );

    function automatic logic [15:0] src_word(input logic [15:0] a);
        return 16'(a - 16'h00FF);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source RAM, result RAM and status register; status goes high 20 cycles after the control write.
    always @(posedge clk) begin
        mem_rdata <= mem_ren ? src_word(mem_radr) : 16'hBEEF;
        if (ren) begin
            if (ibus_radr == STAT_ADR)
                ibus_rdata <= {15'd0, (stat_mode == 1) && ctrl_seen && (cyc >= ctrl_cyc + 20)};
            else
                ibus_rdata <= 16'(ibus_radr - RES_BASE + 16'h000A);
        end else begin
            ibus_rdata <= 16'hDEAD;
        end
    end

    // Scoreboard: every strobe must match the next expected transaction and its cycle slot.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("mem_strobe_excl", 32'(mem_ren & mem_wen), 32'd0);
            checkOutput("ibus_same_adr", 32'(ren && wen && (ibus_radr == ibus_wadr)), 32'd0);
            if (mem_ren) begin
                checkOutput("mem_read_expected", 32'(exp_mem_r.size() > 0), 32'd1);
                if (exp_mem_r.size() > 0) checkOutput("mem_radr", 32'(mem_radr), 32'(exp_mem_r.pop_front()));
                checkOutput("mem_read_cycle", cyc, (rd_idx == 0) ? start_cyc + 1 : first_rd_cyc + rd_idx);
                if (rd_idx == 0) first_rd_cyc = cyc;
                rd_idx++;
            end
            if (wen) begin
                checkOutput("ibus_write_expected", 32'(exp_ibus_w.size() > 0), 32'd1);
                if (exp_ibus_w.size() > 0) begin
                    e_w = exp_ibus_w.pop_front();
                    checkOutput("ibus_wadr", 32'(ibus_wadr), 32'(e_w.adr));
                    checkOutput("ibus_wdata", 32'(ibus_wdata), 32'(e_w.dat));
                end
                if (ibus_wadr == CTRL_ADR) begin
                    checkOutput("ctrl_after_loads", ld_wr_idx, 2 * NPE * int'(cur_len));
                    checkOutput("ctrl_after_last_write", 32'(cyc > last_ld_cyc), 32'd1);
                    ctrl_seen = 1'b1;
                    ctrl_cyc  = cyc;
                    ctrl_data = ibus_wdata;
                end else begin
                    checkOutput("load_write_cycle", cyc, first_rd_cyc + ld_wr_idx + 1);
                    if (ld_wr_idx == 0) first_ld_data = ibus_wdata;
                    last_ld_data = ibus_wdata;
                    last_ld_cyc  = cyc;
                    ld_wr_idx++;
                end
            end
            if (ren && ibus_radr == STAT_ADR) begin
                checkOutput("stat_after_ctrl", 32'(ctrl_seen), 32'd1);
                checkOutput("stat_read_cycle", cyc, (stat_cnt == 0) ? ctrl_cyc + 1 : last_stat_cyc + 2);
                if (stat_mode == 1 && ctrl_seen && cyc >= ctrl_cyc + 20 && stat1_cyc < 0) stat1_cyc = cyc;
                last_stat_cyc = cyc;
                stat_cnt++;
            end else if (ren) begin
                checkOutput("res_read_expected", 32'(exp_res_r.size() > 0), 32'd1);
                if (exp_res_r.size() > 0) checkOutput("res_radr", 32'(ibus_radr), 32'(exp_res_r.pop_front()));
                checkOutput("res_read_cycle", cyc, (res_idx == 0) ? stat1_cyc + 2 : first_res_cyc + res_idx);
                if (res_idx == 0) first_res_cyc = cyc;
                res_idx++;
            end
            if (mem_wen) begin
                checkOutput("mem_write_expected", 32'(exp_mem_w.size() > 0), 32'd1);
                if (exp_mem_w.size() > 0) begin
                    e_m = exp_mem_w.pop_front();
                    checkOutput("mem_wadr", 32'(mem_wadr), 32'(e_m.adr));
                    checkOutput("mem_wdata", 32'(mem_wdata), 32'(e_m.dat));
                end
                checkOutput("mem_write_cycle", cyc, first_res_cyc + mem_w_idx + 1);
                if (mem_w_idx == 0) begin
                    first_mw_adr  = mem_wadr;
                    first_mw_data = mem_wdata;
                end
                last_mem_w_cyc = cyc;
                mem_w_idx++;
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                done_err = err;
                checkOutput("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // kind: 0 = status completes, 1 = status never sets, 2 = zero length
    task automatic buildJob(input logic [7:0] len, input logic [15:0] src, input logic [15:0] dst, input int kind);
        int n;
        n = NPE * int'(len);
        exp_mem_r.delete();
        exp_ibus_w.delete();
        exp_res_r.delete();
        exp_mem_w.delete();
        if (len != 8'd0) begin
            for (int i = 0; i < 2 * n; i++) exp_mem_r.push_back(16'(src + 16'(i)));
            for (int i = 0; i < n; i++)
                exp_ibus_w.push_back('{adr: 16'(A_BASE + 16'(i)), dat: src_word(16'(src + 16'(i)))});
            for (int i = 0; i < n; i++)
                exp_ibus_w.push_back('{adr: 16'(B_BASE + 16'(i)), dat: src_word(16'(src + 16'(n) + 16'(i)))});
            exp_ibus_w.push_back('{adr: CTRL_ADR, dat: {7'd0, 1'b1, len}});
            if (kind == 0) begin
                for (int j = 0; j < NPE * NPE; j++) begin
                    exp_res_r.push_back(16'(RES_BASE + 16'(j)));
                    exp_mem_w.push_back('{adr: 16'(dst + 16'(j)), dat: 16'(16'h000A + 16'(j))});
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] len, input logic [15:0] src, input logic [15:0] dst, input int kind);
        buildJob(len, src, dst, kind);
        cur_len = len;
        stat_mode = (kind == 0) ? 1 : 0;
        rd_idx = 0; ld_wr_idx = 0; last_ld_cyc = -1; ctrl_seen = 1'b0; ctrl_cyc = -100;
        stat_cnt = 0; stat1_cyc = -1; res_idx = 0; mem_w_idx = 0; done_seen = 0;
        first_rd_cyc = -1; first_res_cyc = -1; last_mem_w_cyc = -1; done_cyc = -1;
        @(posedge clk); #1;
        job_start = 1'b1;
        job_len   = len;
        src_base  = src;
        dst_base  = dst;
        start_cyc = cyc;
        @(posedge clk); #1;
        job_start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finishJob(input int kind, input int budget);
        int n;
        n = 0;
        while (done_seen == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("done_within_budget", 32'(done_seen > 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_single_pulse", done_seen, 1);
        checkOutput("err_with_done", 32'(done_err), (kind == 0) ? 32'd0 : 32'd1);
        checkOutput("ibus_writes_left", exp_ibus_w.size(), 0);
        checkOutput("mem_reads_left", exp_mem_r.size(), 0);
        checkOutput("res_reads_left", exp_res_r.size(), 0);
        checkOutput("mem_writes_left", exp_mem_w.size(), 0);
        if (kind == 0) checkOutput("done_after_results", done_cyc, last_mem_w_cyc + 1);
        if (kind == 1) checkOutput("done_after_timeout", done_cyc, ctrl_cyc + int'(TMO_TB) + 2);
        if (kind == 2) checkOutput("done_zero_len", done_cyc, start_cyc + 2);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_strobes", 32'({mem_ren, mem_wen, ren, wen}), 32'd0);
        checkOutput("rst_addresses", 32'(mem_radr | mem_wadr | ibus_radr | ibus_wadr), 32'd0);
        checkOutput("rst_wdata", 32'(ibus_wdata | mem_wdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        applyStimulus(8'd3, 16'h0100, 16'h0300, 0);
        finishJob(0, 300);
        checkOutput("lit_ctrl_word", 32'(ctrl_data), 32'h0103);
        checkOutput("lit_first_a", 32'(first_ld_data), 32'h0001);
        checkOutput("lit_last_b", 32'(last_ld_data), 32'h000C);
        checkOutput("lit_first_res_adr", 32'(first_mw_adr), 32'h0300);
        checkOutput("lit_first_res_data", 32'(first_mw_data), 32'h000A);
        checkOutput("lit_res_after_status", first_res_cyc, ctrl_cyc + 23);

        applyStimulus(8'd1, 16'hFFFE, 16'hFFFE, 0);
        finishJob(0, 300);
        checkOutput("lit_wrap_res_adr", 32'(first_mw_adr), 32'hFFFE);

        applyStimulus(8'd3, 16'h0100, 16'h0300, 0);
        n = 0;
        while (rd_idx <= NPE * 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        job_start = 1'b1;
        job_len   = 8'd5;
        src_base  = 16'h0500;
        dst_base  = 16'h0700;
        @(posedge clk); #1;
        job_start = 1'b0;
        checkOutput("busy_during_stray_start", 32'(busy), 32'd1);
        finishJob(0, 300);

        applyStimulus(8'd2, 16'h0040, 16'h0080, 1);
        finishJob(1, 400);
        checkOutput("timeout_no_results", res_idx + mem_w_idx, 0);

        applyStimulus(8'd0, 16'h0100, 16'h0300, 2);
        finishJob(2, 20);

        applyStimulus(8'd3, 16'h0100, 16'h0300, 0);
        n = 0;
        while (rd_idx < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_mem_r.delete();
        exp_ibus_w.delete();
        exp_res_r.delete();
        exp_mem_w.delete();
        checkOutput("abort_strobes", 32'({mem_ren, mem_wen, ren, wen}), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort_no_done", done_seen, 0);

        applyStimulus(8'd2, 16'h0020, 16'h0060, 0);
        finishJob(0, 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
